// File: rtl/prod_accum_32bit.sv
// Frame accumulator for 32-bit multiplier products with a valid/ready result port.
// Optional build macro PROD_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module prod_accum_32bit #(
    parameter int ACC_W     = 40,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [31:0]      prod,
    input  logic             prod_done,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] term_cnt,
    output logic             busy,
    output logic             ovf,
    output logic             drop
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);
    localparam logic [ACC_W-1:0] ACC_ZERO_C  = ACC_W'(0);
    localparam logic [ACC_W-1:0] ACC_MAX_C   = {ACC_W{1'b1}};
    localparam bit               SINGLE_C    = (FRAME_LEN == 1);

    state_t           state_q, state_d;
    logic             done_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;
    logic             busy_q;

    logic             accept_s;
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic [ACC_W-1:0] add_val_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign accept_s   = prod_done & ~done_q;
    assign prod_ext_s = {{(ACC_W-32){1'b0}}, prod};
    assign sum_s      = {1'b0, acc_q} + {1'b0, prod_ext_s};
    assign carry_s    = sum_s[ACC_W];
    assign cnt_inc_s  = term_cnt_q + CNT_ONE_C;

`ifdef PROD_ACC_SAT_EN
    // Clamp at all-ones; once there, any nonzero addend carries again and re-clamps.
    assign add_val_s = carry_s ? ACC_MAX_C : sum_s[ACC_W-1:0];
`else
    assign add_val_s = sum_s[ACC_W-1:0];
`endif

    // Rising-edge detector on the multiplier done level; reset high so a level present at release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= prod_done;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values; clear outranks everything except rst.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        term_cnt_d     = term_cnt_q;
        ovf_d          = ovf_q;
        drop_d         = drop_q;

        if (clear) begin
            state_d        = ST_IDLE;
            acc_d          = ACC_ZERO_C;
            result_valid_d = 1'b0;
            term_cnt_d     = CNT_ZERO_C;
            ovf_d          = 1'b0;
            drop_d         = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_d      = ACC_ZERO_C;
                    term_cnt_d = CNT_ZERO_C;
                    if (accept_s) begin
                        acc_d      = prod_ext_s;
                        term_cnt_d = CNT_ONE_C;
                        ovf_d      = 1'b0;
                        if (SINGLE_C) begin
                            state_d        = ST_HOLD;
                            result_d       = prod_ext_s;
                            result_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_d      = add_val_s;
                        term_cnt_d = cnt_inc_s;
                        if (carry_s) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_q;
                        end
                        if (cnt_inc_s == FRAME_LEN_C) begin
                            state_d        = ST_HOLD;
                            result_d       = add_val_s;
                            result_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (result_ready && accept_s) begin
                        // Hand off the finished frame and start the next one with this product.
                        acc_d          = prod_ext_s;
                        term_cnt_d     = CNT_ONE_C;
                        ovf_d          = 1'b0;
                        result_valid_d = 1'b0;
                        if (SINGLE_C) begin
                            state_d        = ST_HOLD;
                            result_d       = prod_ext_s;
                            result_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else if (result_ready) begin
                        state_d        = ST_IDLE;
                        acc_d          = ACC_ZERO_C;
                        term_cnt_d     = CNT_ZERO_C;
                        ovf_d          = 1'b0;
                        result_valid_d = 1'b0;
                    end else if (accept_s) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d        = ST_IDLE;
                    acc_d          = ACC_ZERO_C;
                    term_cnt_d     = CNT_ZERO_C;
                    result_valid_d = 1'b0;
                    ovf_d          = 1'b0;
                end
            endcase
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= ACC_ZERO_C;
            result_q       <= ACC_ZERO_C;
            result_valid_q <= 1'b0;
            term_cnt_q     <= CNT_ZERO_C;
            ovf_q          <= 1'b0;
            drop_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            term_cnt_q     <= term_cnt_d;
            ovf_q          <= ovf_d;
            drop_q         <= drop_d;
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign term_cnt     = term_cnt_q;
    assign busy         = busy_q;
    assign ovf          = ovf_q;
    assign drop         = drop_q;

endmodule

// File: tb/tb_prod_accum_32bit.sv
// Directed bench for prod_accum_32bit: default instance plus a narrow ACC_W=34, FRAME_LEN=5 overflow instance.
module tb_prod_accum_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] prod = 32'd0;
    logic        prod_done = 1'b0;
    logic        result_ready = 1'b0;
    logic [39:0] result;
    logic        result_valid;
    logic [7:0]  term_cnt;
    logic        busy, ovf, drop;

    logic        clear2 = 1'b0;
    logic [31:0] prod2 = 32'd0;
    logic        prod_done2 = 1'b0;
    logic        result_ready2 = 1'b0;
    logic [33:0] result2;
    logic        result_valid2;
    logic [7:0]  term_cnt2;
    logic        busy2, ovf2, drop2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prod_accum_32bit dut (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_done(prod_done),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .term_cnt(term_cnt), .busy(busy), .ovf(ovf), .drop(drop)
    );

    prod_accum_32bit #(.ACC_W(34), .FRAME_LEN(5), .CNT_W(8)) u_ovf (
        .clk(clk), .rst(rst), .clear(clear2), .prod(prod2), .prod_done(prod_done2),
        .result(result2), .result_valid(result_valid2), .result_ready(result_ready2),
        .term_cnt(term_cnt2), .busy(busy2), .ovf(ovf2), .drop(drop2)
    );

    // One-cycle done pulse; returns at the falling edge just after the accepting rising edge.
    task automatic pulse(input bit sel, input logic [31:0] p);
        @(negedge clk);
        if (sel) begin prod2 = p; prod_done2 = 1'b1; end
        else begin prod = p; prod_done = 1'b1; end
        @(negedge clk);
        prod_done  = 1'b0;
        prod_done2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        prod_done = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (result !== 40'd0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        tests++; if (term_cnt !== 8'd0) begin fails++; $display("FAIL reset_held_done_cnt: got %0d want 0", term_cnt); end
        tests++; if ({busy, ovf, drop} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, ovf, drop}); end
        prod_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        for (int i = 1; i <= 7; i++) pulse(1'b0, 32'(i));
        tests++; if ({result_valid, term_cnt} !== {1'b0, 8'd7}) begin fails++; $display("FAIL frame_7th: got v=%b cnt=%0d want v=0 cnt=7", result_valid, term_cnt); end
        pulse(1'b0, 32'd8);
        tests++; if (result !== 40'd36) begin fails++; $display("FAIL frame_sum: got %0d want 36", result); end
        tests++; if ({result_valid, busy, ovf} !== 3'b110) begin fails++; $display("FAIL frame_flags: got v/busy/ovf=%b want 110", {result_valid, busy, ovf}); end
        tests++; if (term_cnt !== 8'd8) begin fails++; $display("FAIL frame_cnt: got %0d want 8", term_cnt); end
    endtask

    task automatic test_drop();
        repeat (10) @(negedge clk);
        pulse(1'b0, 32'd99);
        tests++; if ({drop, result_valid} !== 2'b11) begin fails++; $display("FAIL drop_flag: got drop/v=%b want 11", {drop, result_valid}); end
        tests++; if (result !== 40'd36) begin fails++; $display("FAIL drop_result: got %0d want 36", result); end
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        tests++; if ({result_valid, busy, term_cnt} !== {2'b00, 8'd0}) begin fails++; $display("FAIL drop_release: got v=%b busy=%b cnt=%0d want 0 0 0", result_valid, busy, term_cnt); end
        tests++; if (drop !== 1'b1) begin fails++; $display("FAIL drop_sticky: got %b want 1", drop); end
    endtask

    task automatic test_level();
        @(negedge clk);
        prod = 32'h0000_1234;
        prod_done = 1'b1;
        repeat (5) @(negedge clk);
        prod_done = 1'b0;
        @(negedge clk);
        tests++; if (term_cnt !== 8'd1) begin fails++; $display("FAIL level_cnt: got %0d want 1", term_cnt); end
        tests++; if (dut.acc_q !== 40'h12_34) begin fails++; $display("FAIL level_acc: got %h want 1234", dut.acc_q); end
        do_clear();
        tests++; if ({drop, busy, term_cnt} !== {2'b00, 8'd0}) begin fails++; $display("FAIL level_clear: got drop=%b busy=%b cnt=%0d want 0 0 0", drop, busy, term_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) pulse(1'b0, 32'd1);
        tests++; if ({result_valid, result} !== {1'b1, 40'd8}) begin fails++; $display("FAIL b2b_first: got v=%b res=%0d want 1 8", result_valid, result); end
        @(negedge clk);
        result_ready = 1'b1;
        prod = 32'd7;
        prod_done = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        prod_done = 1'b0;
        tests++; if ({result_valid, busy, term_cnt} !== {2'b01, 8'd1}) begin fails++; $display("FAIL b2b_state: got v=%b busy=%b cnt=%0d want 0 1 1", result_valid, busy, term_cnt); end
        tests++; if (dut.acc_q !== 40'd7) begin fails++; $display("FAIL b2b_acc: got %0d want 7", dut.acc_q); end
        tests++; if (drop !== 1'b0) begin fails++; $display("FAIL b2b_nodrop: got %b want 0", drop); end
        do_clear();
    endtask

    task automatic test_clear();
        pulse(1'b0, 32'd10); pulse(1'b0, 32'd20); pulse(1'b0, 32'd30);
        tests++; if ({term_cnt, dut.acc_q} !== {8'd3, 40'd60}) begin fails++; $display("FAIL clear_pre: got cnt=%0d acc=%0d want 3 60", term_cnt, dut.acc_q); end
        do_clear();
        tests++; if ({busy, term_cnt, dut.acc_q} !== {1'b0, 8'd0, 40'd0}) begin fails++; $display("FAIL clear_post: got busy=%b cnt=%0d acc=%0d want 0 0 0", busy, term_cnt, dut.acc_q); end
        @(negedge clk);
        clear = 1'b1; prod = 32'd5; prod_done = 1'b1;
        @(negedge clk);
        clear = 1'b0; prod_done = 1'b0;
        @(negedge clk);
        tests++; if ({busy, term_cnt} !== {1'b0, 8'd0}) begin fails++; $display("FAIL clear_with_accept: got busy=%b cnt=%0d want 0 0", busy, term_cnt); end
        pulse(1'b0, 32'd10); pulse(1'b0, 32'd20); pulse(1'b0, 32'd30);
        do_reset();
        tests++; if ({result, result_valid, term_cnt, busy, ovf, drop} !== {40'd0, 1'b0, 8'd0, 3'b000}) begin fails++; $display("FAIL rst_midframe: got res=%0d v=%b cnt=%0d flags=%b want all 0", result, result_valid, term_cnt, {busy, ovf, drop}); end
        for (int i = 0; i < 8; i++) pulse(1'b0, 32'd1);
        tests++; if ({result_valid, result} !== {1'b1, 40'd8}) begin fails++; $display("FAIL rst_next_frame: got v=%b res=%0d want 1 8", result_valid, result); end
    endtask

    task automatic test_overflow();
        logic [33:0] exp_res;
`ifdef PROD_ACC_SAT_EN
        exp_res = 34'h3_FFFF_FFFF;
`else
        exp_res = 34'h0_FFFF_FFFB;
`endif
        for (int i = 0; i < 4; i++) pulse(1'b1, 32'hFFFF_FFFF);
        tests++; if ({ovf2, result_valid2, term_cnt2} !== {2'b00, 8'd4}) begin fails++; $display("FAIL ovf_pre: got ovf=%b v=%b cnt=%0d want 0 0 4", ovf2, result_valid2, term_cnt2); end
        pulse(1'b1, 32'hFFFF_FFFF);
        tests++; if ({ovf2, result_valid2} !== 2'b11) begin fails++; $display("FAIL ovf_flag: got ovf/v=%b want 11", {ovf2, result_valid2}); end
        tests++; if (result2 !== exp_res) begin fails++; $display("FAIL ovf_result: got %h want %h", result2, exp_res); end
        @(negedge clk);
        result_ready2 = 1'b1;
        @(negedge clk);
        result_ready2 = 1'b0;
        tests++; if ({ovf2, result_valid2, busy2} !== 3'b000) begin fails++; $display("FAIL ovf_release: got ovf/v/busy=%b want 000", {ovf2, result_valid2, busy2}); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_drop();
        test_level();
        test_back_to_back();
        test_clear();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prod_accum_32bit.md
# prod_accum_32bit

Downstream consumer of the 16-bit sequential multiplier. Captures each 32-bit product when the multiplier's `done` rises and accumulates a fixed-length frame of products into a wide accumulator. Presents the frame sum through a valid/ready handshake to the next stage, such as a filter-tap or dot-product output register.

## Interface
Parameters:
- `ACC_W`, 40: accumulator/result width; legal range 33..64.
- `FRAME_LEN`, 8: products per frame; legal range 1..2^CNT_W-1.
- `CNT_W`, 8: width of the term counter.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clear` in 1: synchronous frame abort.
- `prod` in 32: product from the multiplier (`yout`); must be valid in the first cycle `prod_done` is high.
- `prod_done` in 1: multiplier `done`; level signal that stays high until the multiplier is reset.
- `result` out ACC_W: frame sum; stable while `result_valid`=1.
- `result_valid` out 1: frame sum available.
- `result_ready` in 1: downstream accepts `result`.
- `term_cnt` out CNT_W: products accumulated in the current frame.
- `busy` out 1: state is not IDLE.
- `ovf` out 1: sticky per frame; set when the accumulator exceeded ACC_W bits.
- `drop` out 1: sticky; set when a product arrived in HOLD and was discarded.

## Operation
- Edge detect: register `done_q` <= `prod_done` every cycle, reset value 1.
  - `accept` = `prod_done & ~done_q`.
  - A level held high counts once.
  - `prod_done` already high at reset release is not counted.
- Priority: `rst` > `clear` > state logic.
- States: IDLE, ACCUM, HOLD.
- IDLE: accumulator = 0, `term_cnt`=0.
  - On `accept`: acc <= `prod` (zero-extended), `term_cnt` <= 1.
  - Go to ACCUM, or directly to HOLD if FRAME_LEN==1.
- ACCUM: on `accept`: acc <= acc + `prod`, `term_cnt` <= `term_cnt`+1.
  - When the new count equals FRAME_LEN: go to HOLD and load `result` with the new sum.
- HOLD: `result_valid`=1; `result` is frozen.
  - `accept` without `result_ready`: product discarded, `drop` <= 1.
  - `result_ready` without `accept`: go to IDLE; `result_valid` <= 0, `term_cnt` <= 0, `ovf` <= 0.
  - `result_ready` with `accept` in the same cycle: frame handed off and the new product starts the next frame.
    - acc <= `prod`, `term_cnt` <= 1, state ACCUM (HOLD if FRAME_LEN==1).
- `clear`: state IDLE; acc, `term_cnt`, `result_valid`, `ovf`, `drop` <= 0.
  - An `accept` in the same cycle is discarded.
  - `done_q` still updates.
- `drop` is cleared only by `rst` or `clear`.
- Arithmetic: unsigned; the sum is computed at ACC_W+1 bits.
  - Carry out sets `ovf`.
  - Stored value is per Configuration.

## Timing
- Reset values: `result`=0, `result_valid`=0, `term_cnt`=0, `busy`=0, `ovf`=0, `drop`=0; state IDLE.
- Latency: an accepted product is reflected in acc/`term_cnt` after the same edge at which `accept` is sampled (1 cycle from `prod_done` rising).
- The final accept of a frame asserts `result_valid` at that same edge; `result` equals the complete sum.
- `result_valid` stays high until the edge at which `result_ready`=1 is sampled.
- Minimum spacing between accepts: 2 cycles (`prod_done` must fall between them).
- `rst` or `clear` mid-frame discards the partial sum; the next `accept` starts a new frame.

## Configuration
- `PROD_ACC_SAT_EN` defined: on carry out, acc clamps to 2^ACC_W-1 and further additions hold it there; `ovf`=1.
- `PROD_ACC_SAT_EN` undefined: acc wraps modulo 2^ACC_W; `ovf`=1.
- Handshake, counting and timing are identical in both builds.

## Test plan
- Default params, rst, then products 1..8 each on a fresh `done` pulse -> `result`=36, `result_valid` rises at the 8th accept edge, `term_cnt`=8, `ovf`=0.
- `prod_done` held high 5 cycles with `prod`=0x0000_1234 -> `term_cnt` increments by exactly 1; acc=0x1234.
- Frame complete, `result_ready` low 10 cycles, extra `done` pulse with `prod`=99 -> `drop`=1, `result` unchanged. Then `result_ready`=1 -> IDLE, `result_valid`=0, `term_cnt`=0.
- In HOLD, `result_ready` and `accept` in the same cycle with `prod`=7 -> previous `result` consumed; state ACCUM, acc=7, `term_cnt`=1.
- ACC_W=34, FRAME_LEN=5, five products 0xFFFF_FFFF -> `ovf`=1.
  - Macro undefined: `result`=0x0_FFFF_FFFB.
  - Macro defined: `result`=0x3_FFFF_FFFF.
- After 3 products (10, 20, 30), assert `clear` for 1 cycle -> acc=0, `term_cnt`=0, `busy`=0. Repeat with `rst` -> all outputs at reset values; a following frame of eight 1s -> `result`=8.
